// File: rtl/clint_irq_pkg.sv
// Shared core constants: CLINT register offsets, reset values, CSR indices
// and small helpers used by the CLINT and its bench.
package clint_irq_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    // Word offsets of the CLINT registers (byte addresses, bits [1:0] ignored)
    localparam logic [ADDR_W-1:0] OFF_MSIP        = 5'h00;
    localparam logic [ADDR_W-1:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [ADDR_W-1:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [ADDR_W-1:0] OFF_MTIME_LO    = 5'h10;
    localparam logic [ADDR_W-1:0] OFF_MTIME_HI    = 5'h14;

    // MTIMECMP comes out of reset as far away as possible
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // CSR indices of the machine interrupt CSRs fed by this block
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Bit positions inside MIP/MIE
    localparam int unsigned MIP_MSIP_BIT = 3;
    localparam int unsigned MIP_MTIP_BIT = 7;
    localparam int unsigned MIP_MEIP_BIT = 11;

    typedef enum logic [2:0] {
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_NONE
    } reg_sel_e;

    // Map a byte address onto the register it selects
    function automatic reg_sel_e decode_addr(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] word;
        word = addr & 5'b11100;
        case (word)
            OFF_MSIP:        return REG_MSIP;
            OFF_MTIMECMP_LO: return REG_CMP_LO;
            OFF_MTIMECMP_HI: return REG_CMP_HI;
            OFF_MTIME_LO:    return REG_MTIME_LO;
            OFF_MTIME_HI:    return REG_MTIME_HI;
            default:         return REG_NONE;
        endcase
    endfunction

    // Replace the byte lanes of old selected by sel with those of wdata
    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old,
                                                      input logic [DATA_W-1:0] wdata,
                                                      input logic [3:0]        sel);
        logic [DATA_W-1:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/clint_irq_if.sv
// Register bus between a master and the CLINT.
// Valid/ready rule: a request (stb with we/addr/wdata/sel) is accepted on the
// rising edge where stb=1 and ack=0; ack is then high for exactly one cycle,
// carrying rdata for reads. The master keeps the request stable until it sees
// ack, and a strobe seen while ack=1 is not a new request.
interface clint_irq_if;
    import clint_irq_pkg::*;

    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        sel;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output stb, we, addr, wdata, sel,
        input  ack, rdata
    );

    modport slave (
        input  stb, we, addr, wdata, sel,
        output ack, rdata
    );

endinterface

// File: rtl/clint_irq_sync.sv
// irq_sync: multi-flop synchroniser for an asynchronous level input.
module irq_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw level through the flop chain; oldest sample is the output
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_async};
        end
    end

    assign o_sync = sync_q[STAGES-1];

endmodule

// File: rtl/clint_irq.sv
// clint_irq: core-local interruptor with MSIP, 64-bit MTIME/MTIMECMP,
// a timer prescaler, an atomic MTIME read shadow and the external-interrupt
// synchroniser.
module clint_irq
    import clint_irq_pkg::*;
#(
    parameter int unsigned PRESCALE    = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    clint_irq_if.slave  bus,
    input  logic        i_ext_irq,
    output logic        o_external_interrupt,
    output logic        o_software_interrupt,
    output logic        o_timer_interrupt
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    // Bus handshake and read path
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;

    // Architectural registers
    logic              msip_q, msip_d;
    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       cmp_q, cmp_d;
    logic              armed_q, armed_d;
    logic              tip_q, tip_d;
    logic [PRE_W-1:0]  pre_q, pre_d;

    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic              tick;
    reg_sel_e          reg_sel;
    logic [DATA_W-1:0] rd_word;

    // Request acceptance and register selection
    always_comb begin
        accept  = bus.stb && !ack_q;
        wr_en   = accept && bus.we;
        rd_en   = accept && !bus.we;
        reg_sel = decode_addr(bus.addr);
    end

    // Prescaler: MTIME advances whenever the counter wraps
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    // Read mux over the current register values
    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_MSIP:     rd_word = {{(DATA_W-1){1'b0}}, msip_q};
            REG_CMP_LO:   rd_word = cmp_q[31:0];
            REG_CMP_HI:   rd_word = cmp_q[63:32];
            REG_MTIME_LO: rd_word = mtime_q[31:0];
            REG_MTIME_HI: rd_word = shadow_q;
            default:      rd_word = '0;
        endcase
    end

    // Read data is only non-zero in the ack cycle of a read; a read of
    // MTIME_LO captures the upper half so a following HI read is coherent
    always_comb begin
        ack_d    = accept;
        rdata_d  = rd_en ? rd_word : '0;
        shadow_d = shadow_q;
        if (rd_en && (reg_sel == REG_MTIME_LO)) begin
            shadow_d = mtime_q[63:32];
        end
    end

    // Register writes; a write to either MTIME half replaces that cycle's
    // increment entirely
    always_comb begin
        msip_d  = msip_q;
        cmp_d   = cmp_q;
        armed_d = armed_q;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr_en) begin
            case (reg_sel)
                REG_MSIP: begin
                    if (bus.sel[0]) msip_d = bus.wdata[0];
                end
                REG_CMP_LO: begin
                    cmp_d[31:0] = merge_bytes(cmp_q[31:0], bus.wdata, bus.sel);
                    armed_d     = armed_q | (|bus.sel);
                end
                REG_CMP_HI: begin
                    cmp_d[63:32] = merge_bytes(cmp_q[63:32], bus.wdata, bus.sel);
                    armed_d      = armed_q | (|bus.sel);
                end
                REG_MTIME_LO: begin
                    mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], bus.wdata, bus.sel)};
                end
                REG_MTIME_HI: begin
                    mtime_d = {merge_bytes(mtime_q[63:32], bus.wdata, bus.sel), mtime_q[31:0]};
                end
                default: ;
            endcase
        end
    end

    // Timer request follows the registered compare; it stays quiet after
    // reset until software has programmed MTIMECMP at least once
    always_comb begin
        tip_d = armed_q && (mtime_q >= cmp_q);
    end

    // State registers; reset drops any request in flight without side effects
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            shadow_q <= '0;
            msip_q   <= 1'b0;
            mtime_q  <= '0;
            cmp_q    <= MTIMECMP_RST;
            armed_q  <= 1'b0;
            tip_q    <= 1'b0;
            pre_q    <= '0;
        end else begin
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            shadow_q <= shadow_d;
            msip_q   <= msip_d;
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            armed_q  <= armed_d;
            tip_q    <= tip_d;
            pre_q    <= pre_d;
        end
    end

    irq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ext_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_ext_irq),
        .o_sync  (o_external_interrupt)
    );

    assign bus.ack              = ack_q;
    assign bus.rdata            = rdata_q;
    assign o_software_interrupt = msip_q;
    assign o_timer_interrupt    = tip_q;

endmodule

// File: tb/tb_clint_irq.sv
// Bench for clint_irq: directed scenarios plus random bus traffic, checked
// every cycle against a transaction-level model of the register file.
module tb_clint_irq;
    import clint_irq_pkg::*;

    localparam int unsigned P = 4;
    localparam int unsigned S = 2;

    logic clk;
    logic rst;
    logic ext;
    logic o_eip, o_sip, o_tip;

    clint_irq_if bus ();

    clint_irq #(
        .PRESCALE    (P),
        .SYNC_STAGES (S)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .bus                  (bus),
        .i_ext_irq            (ext),
        .o_external_interrupt (o_eip),
        .o_software_interrupt (o_sip),
        .o_timer_interrupt    (o_tip)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input logic [63:0] act,
                             input logic [63:0] lo, input logic [63:0] hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time is counted in cycles since reset: every P-th cycle is a tick.
    logic [63:0] m_mtime, m_cmp, m_nxt;
    logic [31:0] m_shadow, m_rdata;
    logic        m_msip, m_ack, m_tip, m_armed, m_acc, m_tick;
    int unsigned m_cyc;
    int unsigned m_word;
    bit          m_valid = 0;
    logic        hist[$];

    function automatic logic [31:0] model_read(input int unsigned word);
        case (word)
            0:       return {31'b0, m_msip};
            8:       return m_cmp[31:0];
            12:      return m_cmp[63:32];
            16:      return m_mtime[31:0];
            20:      return m_shadow;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mtime  = 64'h0;
            m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
            m_shadow = 32'h0;
            m_rdata  = 32'h0;
            m_msip   = 1'b0;
            m_ack    = 1'b0;
            m_tip    = 1'b0;
            m_armed  = 1'b0;
            m_cyc    = 0;
            hist     = {};
            for (int k = 0; k < S; k++) hist.push_back(1'b0);
            m_valid  = 1;
        end else if (m_valid) begin
            m_acc  = bus.stb && !m_ack;
            m_word = 32'(bus.addr) & 32'h1C;
            m_tick = (m_cyc % P) == (P - 1);
            m_cyc++;
            m_tip   = m_armed && (m_mtime >= m_cmp);
            m_rdata = (m_acc && !bus.we) ? model_read(m_word) : 32'h0;
            if (m_acc && !bus.we && m_word == 16) m_shadow = m_mtime[63:32];
            m_nxt = m_tick ? m_mtime + 64'd1 : m_mtime;
            if (m_acc && bus.we) begin
                case (m_word)
                    0:  if (bus.sel[0]) m_msip = bus.wdata[0];
                    8:  begin
                            m_cmp[31:0] = lanes(m_cmp[31:0], bus.wdata, bus.sel);
                            if (bus.sel != 0) m_armed = 1'b1;
                        end
                    12: begin
                            m_cmp[63:32] = lanes(m_cmp[63:32], bus.wdata, bus.sel);
                            if (bus.sel != 0) m_armed = 1'b1;
                        end
                    16: m_nxt = {m_mtime[63:32], lanes(m_mtime[31:0], bus.wdata, bus.sel)};
                    20: m_nxt = {lanes(m_mtime[63:32], bus.wdata, bus.sel), m_mtime[31:0]};
                    default: ;
                endcase
            end
            m_mtime = m_nxt;
            m_ack   = m_acc;
            hist.push_front(ext);
            void'(hist.pop_back());
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ack", {63'b0, bus.ack}, {63'b0, m_ack});
            chk("rdata", {32'b0, bus.rdata}, {32'b0, m_rdata});
            chk("timer_irq", {63'b0, o_tip}, {63'b0, m_tip});
            chk("sw_irq", {63'b0, o_sip}, {63'b0, m_msip});
            chk("ext_irq", {63'b0, o_eip}, {63'b0, hist[S-1]});
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic bus_xfer(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                            input logic [3:0] sel, output logic [31:0] rdata);
        bit got;
        got       = 0;
        bus.stb   = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
        bus.sel   = sel;
        rdata     = 32'h0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus.ack) begin
                got   = 1;
                rdata = bus.rdata;
            end
        end
        bus.stb = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack expected ack within 20 cycles at %0t", $time);
        end
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] sel);
        logic [31:0] dummy;
        bus_xfer(1'b1, addr, data, sel, dummy);
    endtask

    task automatic rd(input logic [4:0] addr, output logic [31:0] data);
        bus_xfer(1'b0, addr, 32'h0, 4'h0, data);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    logic [31:0] rv;
    bit          rand_done;
    int          first_hi, n_hi;
    bit          seen;

    initial begin
        rst       = 1'b1;
        ext       = 1'b0;
        bus.stb   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.sel   = '0;
        rand_done = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values of MTIMECMP and the timer request
        rd(OFF_MTIMECMP_LO, rv);
        chk("cmp_lo_reset", {32'b0, rv}, 64'hFFFF_FFFF);
        rd(OFF_MTIMECMP_HI, rv);
        chk("cmp_hi_reset", {32'b0, rv}, 64'hFFFF_FFFF);
        chk("tip_reset", {63'b0, o_tip}, 64'h0);

        // 40 cycles at prescale 4 give MTIME = 10
        do_reset(2);
        repeat (40) @(negedge clk);
        rd(OFF_MTIME_LO, rv);
        chk_range("mtime_after_40", {32'b0, rv}, 9, 11);

        // Carry from low to high half, read atomically through the shadow
        wr(OFF_MTIME_HI, 32'h0, 4'hF);
        wr(OFF_MTIME_LO, 32'hFFFF_FFFF, 4'hF);
        repeat (P + 1) @(negedge clk);
        rd(OFF_MTIME_LO, rv);
        chk_range("mtime_lo_wrapped", {32'b0, rv}, 0, 3);
        rd(OFF_MTIME_HI, rv);
        chk("mtime_hi_shadow", {32'b0, rv}, 64'h1);

        // Timer compare at 20, then pushed out to 1000
        wr(OFF_MTIME_HI, 32'h0, 4'hF);
        wr(OFF_MTIME_LO, 32'h0, 4'hF);
        wr(OFF_MTIMECMP_HI, 32'h0, 4'hF);
        wr(OFF_MTIMECMP_LO, 32'd20, 4'hF);
        @(negedge clk);
        chk("tip_before_20", {63'b0, o_tip}, 64'h0);
        seen = 0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (o_tip) seen = 1;
        end
        chk("tip_rises", {63'b0, seen}, 64'h1);
        rd(OFF_MTIME_LO, rv);
        chk_range("mtime_at_tip", {32'b0, rv}, 20, 22);
        wr(OFF_MTIMECMP_LO, 32'd1000, 4'hF);
        repeat (2) @(negedge clk);
        chk("tip_cleared", {63'b0, o_tip}, 64'h0);

        // Software interrupt and byte enables
        wr(OFF_MSIP, 32'h1, 4'b0001);
        @(negedge clk);
        chk("msip_set", {63'b0, o_sip}, 64'h1);
        wr(OFF_MSIP, 32'h0, 4'b0000);
        @(negedge clk);
        chk("msip_sel0", {63'b0, o_sip}, 64'h1);
        wr(OFF_MSIP, 32'h0, 4'b0001);
        @(negedge clk);
        chk("msip_clear", {63'b0, o_sip}, 64'h0);
        wr(5'h18, 32'hDEAD_BEEF, 4'hF);
        rd(5'h18, rv);
        chk("unmapped_reads_0", {32'b0, rv}, 64'h0);

        // External interrupt: 3-cycle pulse appears 3 cycles long, S cycles late
        ext = 1'b1;
        first_hi = -1;
        n_hi = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) ext = 1'b0;
            if (o_eip) begin
                n_hi++;
                if (first_hi < 0) first_hi = k;
            end
        end
        chk("ext_high_cycles", 64'(n_hi), 64'd3);
        chk("ext_delay", 64'(first_hi), 64'(S));

        // Reset while a write to MTIMECMP_LO is pending: no ack, no write
        bus.stb   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = OFF_MTIMECMP_LO;
        bus.wdata = 32'h5;
        bus.sel   = 4'hF;
        rst       = 1'b1;
        seen      = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.ack) seen = 1;
        end
        bus.stb = 1'b0;
        rst     = 1'b0;
        chk("no_ack_in_reset", {63'b0, seen}, 64'h0);
        rd(OFF_MTIMECMP_LO, rv);
        chk("no_partial_write", {32'b0, rv}, 64'hFFFF_FFFF);

        // Unarmed timer stays low even when MTIME passes all-ones
        wr(OFF_MTIME_HI, 32'hFFFF_FFFF, 4'hF);
        wr(OFF_MTIME_LO, 32'hFFFF_FFF8, 4'hF);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_tip) seen = 1;
        end
        chk("tip_unarmed", {63'b0, seen}, 64'h0);

        // Random traffic with a wandering external line
        fork
            begin
                for (int n = 0; n < 250; n++) begin
                    logic [4:0]  a;
                    logic [31:0] d;
                    a = 5'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
                    d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
                    if ($urandom_range(0, 1) == 1)
                        wr(a, d, 4'($urandom_range(0, 15)));
                    else
                        rd(a, rv);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    if ($urandom_range(0, 3) == 0) ext = ~ext;
                end
            end
        join

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
